snd_sequencer: RTL

Sound-event scheduler between the game logic controller and the board buzzer. Accepts the one-cycle `snd_trig`/`snd_evt` pulses (EAT, OVER, START) and arbitrates them by priority, with one pending slot. Plays each accepted event as a fixed sequence of square-wave notes on a single buzzer pin, inserting a silent gap between back-to-back events.

---
 rtl/snd_pkg.sv | 64 ++++++
 rtl/snd_tone_gen.sv | 54 +++++
 rtl/snd_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/snd_pkg.sv
// -----------------------------------------------------------------------------
// snd_pkg
// Shared definitions for the buzzer sound sequencer:
//   - event codes (same encoding as the game logic controller)
//   - note and sequencer state enumerations
//   - event priority, sequence length and note lookup helpers
// -----------------------------------------------------------------------------
package snd_pkg;

  localparam logic [1:0] SND_NONE  = 2'b00;
  localparam logic [1:0] SND_EAT   = 2'b01;
  localparam logic [1:0] SND_OVER  = 2'b10;
  localparam logic [1:0] SND_START = 2'b11;

  typedef enum logic [1:0] {
    NOTE_LO  = 2'd0,
    NOTE_MID = 2'd1,
    NOTE_HI  = 2'd2
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Larger value wins: OVER > START > EAT > none.
  function automatic logic [1:0] snd_prio(input logic [1:0] evt);
    logic [1:0] p;
    case (evt)
      SND_OVER:  p = 2'd3;
      SND_START: p = 2'd2;
      SND_EAT:   p = 2'd1;
      default:   p = 2'd0;
    endcase
    return p;
  endfunction

  // Number of notes in an event's sequence.
  function automatic logic [1:0] snd_seq_len(input logic [1:0] evt);
    logic [1:0] n;
    case (evt)
      SND_EAT:   n = 2'd2;
      SND_START: n = 2'd3;
      SND_OVER:  n = 2'd3;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

  // Note played at position idx of an event's sequence.
  function automatic note_t snd_note_at(input logic [1:0] evt, input logic [1:0] idx);
    note_t n;
    n = NOTE_LO;
    case (evt)
      SND_EAT:   n = (idx == 2'd0) ? NOTE_MID : NOTE_HI;
      SND_START: n = (idx == 2'd0) ? NOTE_LO : ((idx == 2'd1) ? NOTE_MID : NOTE_HI);
      SND_OVER:  n = (idx == 2'd0) ? NOTE_HI : ((idx == 2'd1) ? NOTE_MID : NOTE_LO);
      default:   n = NOTE_LO;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snd_tone_gen.sv
// -----------------------------------------------------------------------------
// snd_tone_gen
// Square-wave generator: a half-period counter plus a toggle flop. The output
// is registered and already gated by mute.
//   clk        system clock
//   rst        synchronous active-high reset
//   i_restart  start a new note: counter to 0, tone high on the next cycle
//   i_run      tone keeps running; when low the tone is forced low
//   i_mute     forces the registered buzzer output low
//   i_half     half-period in clk cycles of the current note (>= 2)
//   o_buzz     registered buzzer drive
// -----------------------------------------------------------------------------
module snd_tone_gen #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_restart,
  input  logic          i_run,
  input  logic          i_mute,
  input  logic [CW-1:0] i_half,
  output logic          o_buzz
);

  logic [CW-1:0] r_cnt;
  logic          r_tone;
  logic          r_buzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
      r_buzz <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tone <= 1'b1;
      r_buzz <= ~i_mute;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
      r_buzz <= 1'b0;
    end else if (r_cnt == i_half - CW'(1)) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
      r_buzz <= ~r_tone & ~i_mute;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_buzz <= r_tone & ~i_mute;
    end
  end

  assign o_buzz = r_buzz;

endmodule

// File: rtl/snd_sequencer.sv
// -----------------------------------------------------------------------------
// snd_sequencer
// Sound-event scheduler between the game logic controller and the buzzer.
// Accepts triggered event codes, arbitrates them by priority with a single
// pending slot, and plays each event as a fixed series of square-wave notes
// with a silent gap between back-to-back events.
//   clk          system clock
//   rst          synchronous active-high reset
//   snd_evt_in   event code: 01 EAT, 10 OVER, 11 START, 00 none
//   snd_trig_in  one-cycle strobe qualifying snd_evt_in
//   mute_in      level; forces the buzzer low while sequencing continues
//   buzz_out     square-wave buzzer drive (registered)
//   busy_out     high while playing or in the inter-event gap (registered)
//   cur_evt_out  code of the event playing, 00 otherwise (registered)
// -----------------------------------------------------------------------------
module snd_sequencer
  import snd_pkg::*;
#(
  parameter int HALF_LO  = 50_000,
  parameter int HALF_MID = 37_500,
  parameter int HALF_HI  = 25_000,
  parameter int NOTE_LEN = 10_000_000,
  parameter int GAP_LEN  = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] snd_evt_in,
  input  logic       snd_trig_in,
  input  logic       mute_in,
  output logic       buzz_out,
  output logic       busy_out,
  output logic [1:0] cur_evt_out
);

  localparam int MAX_HALF = (HALF_LO > HALF_MID) ?
                            ((HALF_LO > HALF_HI) ? HALF_LO : HALF_HI) :
                            ((HALF_MID > HALF_HI) ? HALF_MID : HALF_HI);
  localparam int MAX_LEN  = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int MAX_ALL  = (MAX_HALF > MAX_LEN) ? MAX_HALF : MAX_LEN;
  localparam int CW       = $clog2(MAX_ALL);

  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  state_t        r_state;
  logic [1:0]    r_evt;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_note_cnt;
  logic [CW-1:0] r_gap_cnt;
  logic          r_pend_vld;
  logic [1:0]    r_pend_evt;
  logic          r_busy;
  logic [1:0]    r_cur_evt;

  state_t        w_state_nxt;
  logic [1:0]    w_evt_nxt;
  logic [1:0]    w_idx_nxt;
  logic [CW-1:0] w_note_cnt_nxt;
  logic [CW-1:0] w_gap_cnt_nxt;
  logic          w_pend_vld_nxt;
  logic [1:0]    w_pend_evt_nxt;
  logic          w_restart;

  logic          w_trig_ok;
  logic [1:0]    w_new_prio;
  logic          w_note_wrap;
  logic          w_last_note;
  logic [CW-1:0] w_half;

  assign w_trig_ok   = snd_trig_in && (snd_evt_in != SND_NONE);
  assign w_new_prio  = snd_prio(snd_evt_in);
  assign w_note_wrap = (r_note_cnt == NOTE_LAST);
  assign w_last_note = w_note_wrap && (r_idx == snd_seq_len(r_evt) - 2'd1);

  // Half-period of the note currently sounding; only consulted while the
  // tone generator is counting, never on the restart cycle.
  always_comb begin
    w_half = CW'(HALF_LO);
    case (snd_note_at(r_evt, r_idx))
      NOTE_LO:  w_half = CW'(HALF_LO);
      NOTE_MID: w_half = CW'(HALF_MID);
      NOTE_HI:  w_half = CW'(HALF_HI);
      default:  w_half = CW'(HALF_LO);
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_evt_nxt      = r_evt;
    w_idx_nxt      = r_idx;
    w_note_cnt_nxt = r_note_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_evt_nxt = r_pend_evt;
    w_restart      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_trig_ok) begin
          w_state_nxt    = ST_PLAY;
          w_evt_nxt      = snd_evt_in;
          w_idx_nxt      = 2'd0;
          w_note_cnt_nxt = '0;
          w_restart      = 1'b1;
        end
      end

      ST_PLAY: begin
        if (w_trig_ok && (w_new_prio >= snd_prio(r_evt))) begin
          // Preempt: restart from note 0 of the new event, pending untouched.
          w_evt_nxt      = snd_evt_in;
          w_idx_nxt      = 2'd0;
          w_note_cnt_nxt = '0;
          w_restart      = 1'b1;
        end else begin
          if (w_trig_ok && (!r_pend_vld || (w_new_prio > snd_prio(r_pend_evt)))) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_evt_nxt = snd_evt_in;
          end
          if (w_last_note) begin
            // A trigger pended on this same cycle still earns a gap.
            w_note_cnt_nxt = '0;
            w_idx_nxt      = 2'd0;
            w_gap_cnt_nxt  = '0;
            if (w_pend_vld_nxt) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_IDLE;
              w_evt_nxt   = SND_NONE;
            end
          end else if (w_note_wrap) begin
            w_idx_nxt      = r_idx + 2'd1;
            w_note_cnt_nxt = '0;
            w_restart      = 1'b1;
          end else begin
            w_note_cnt_nxt = r_note_cnt + CW'(1);
          end
        end
      end

      ST_GAP: begin
        if (w_trig_ok && (w_new_prio >= snd_prio(r_pend_evt))) begin
          w_pend_evt_nxt = snd_evt_in;
        end
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt    = ST_PLAY;
          w_evt_nxt      = w_pend_evt_nxt;
          w_pend_vld_nxt = 1'b0;
          w_idx_nxt      = 2'd0;
          w_note_cnt_nxt = '0;
          w_gap_cnt_nxt  = '0;
          w_restart      = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_evt      <= SND_NONE;
      r_idx      <= 2'd0;
      r_note_cnt <= '0;
      r_gap_cnt  <= '0;
      r_pend_vld <= 1'b0;
      r_pend_evt <= SND_NONE;
      r_busy     <= 1'b0;
      r_cur_evt  <= SND_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_evt      <= w_evt_nxt;
      r_idx      <= w_idx_nxt;
      r_note_cnt <= w_note_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_evt <= w_pend_evt_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_cur_evt  <= (w_state_nxt == ST_PLAY) ? w_evt_nxt : SND_NONE;
    end
  end

  snd_tone_gen #(
    .CW (CW)
  ) u_tone (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .i_run     (w_state_nxt == ST_PLAY),
    .i_mute    (mute_in),
    .i_half    (w_half),
    .o_buzz    (buzz_out)
  );

  assign busy_out    = r_busy;
  assign cur_evt_out = r_cur_evt;

endmodule
